// File: rtl/rr_demux_ctrl.sv
// Round-robin scheduler: pops the shared source FIFO, steers the 4-way demux, strobes the destination FIFO push.
// pop/select are combinational in the grant cycle, push lands one cycle later; full destinations are skipped, and enable low or an empty source holds off.
module rr_demux_ctrl #(
   parameter int BURST = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [3:0] dest_full,
   output logic       pop,
   output logic [1:0] select,
   output logic [3:0] push,
   output logic       idle
);

   localparam logic [4:0] BURST_LEN = 5'(BURST);

   logic [1:0] ptr;
   logic [1:0] ptr_nxt;
   logic [1:0] target;
   logic [3:0] burst_cnt;
   logic [3:0] cnt_nxt;
   logic [3:0] push_q;
   logic       grant;

   // Walk the offsets from the farthest to the nearest so that the closest eligible destination wins.
   always_comb begin
      target = ptr;
      for (int i = 3; i >= 0; i--) begin
         if (!dest_full[ptr + 2'(i)]) begin
            target = ptr + 2'(i);
         end
      end
   end

   assign grant  = reset & enable & ~fifo_empty & ~(&dest_full);
   assign pop    = grant;
   assign select = !reset ? 2'd0 : (grant ? target : ptr);
   assign push   = push_q;

   // A skip hands the burst to the new holder when bursts are longer than one word.
   always_comb begin
      ptr_nxt = ptr;
      cnt_nxt = burst_cnt;
      if (grant) begin
         if (target == ptr && ({1'b0, burst_cnt} + 5'd1) < BURST_LEN) begin
            cnt_nxt = burst_cnt + 4'd1;
         end else if (target != ptr && BURST_LEN > 5'd1) begin
            ptr_nxt = target;
            cnt_nxt = 4'd1;
         end else begin
            ptr_nxt = target + 2'd1;
            cnt_nxt = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= 2'd0;
         burst_cnt <= 4'd0;
         push_q    <= 4'd0;
         idle      <= 1'b1;
      end else begin
         ptr       <= ptr_nxt;
         burst_cnt <= cnt_nxt;
         push_q    <= grant ? (4'b0001 << target) : 4'd0;
         idle      <= ~grant;
      end
   end

endmodule

// File: tb/tb_rr_demux_ctrl.sv
// Bench for rr_demux_ctrl: BURST=1 and BURST=3 instances share stimulus and are checked against a rule-level model.
module tb_rr_demux_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [3:0] dest_full = 4'd0;

   logic       pop1, pop3, idle1, idle3;
   logic [1:0] sel1, sel3;
   logic [3:0] push1, push3;

   int checks = 0;
   int errors = 0;

   int m_ptr [2];
   int m_cnt [2];
   int m_push [2];
   int m_idle;
   int bursts [2] = '{1, 3};
   bit last_g;
   int sel_log1 [$];
   int sel_log3 [$];

   always #5 clk = ~clk;

   rr_demux_ctrl #(.BURST(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .dest_full(dest_full), .pop(pop1), .select(sel1), .push(push1), .idle(idle1)
   );

   rr_demux_ctrl #(.BURST(3)) u_dut3 (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .dest_full(dest_full), .pop(pop3), .select(sel3), .push(push3), .idle(idle3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_elig(input int p, input logic [3:0] f);
      for (int k = 0; k < 4; k++) begin
         if (!f[(p + k) % 4]) return (p + k) % 4;
      end
      return p;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d]  = 0;
         m_cnt[d]  = 0;
         m_push[d] = 0;
      end
      m_idle = 1;
   endtask

   // One clock cycle: drive, check combinational and registered outputs, advance the model at the edge.
   task automatic step(input bit en, input bit emp, input logic [3:0] full);
      bit g;
      int tgt [2];
      enable     = en;
      fifo_empty = emp;
      dest_full  = full;
      #1;
      g = en && !emp && (full != 4'hF);
      for (int d = 0; d < 2; d++) tgt[d] = first_elig(m_ptr[d], full);
      chk("pop1", 32'(pop1), 32'(g));
      chk("sel1", 32'(sel1), g ? tgt[0] : m_ptr[0]);
      chk("push1", 32'(push1), m_push[0]);
      chk("idle1", 32'(idle1), m_idle);
      chk("pop3", 32'(pop3), 32'(g));
      chk("sel3", 32'(sel3), g ? tgt[1] : m_ptr[1]);
      chk("push3", 32'(push3), m_push[1]);
      chk("idle3", 32'(idle3), m_idle);
      if (g) begin
         sel_log1.push_back(int'(sel1));
         sel_log3.push_back(int'(sel3));
      end
      last_g = g;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (g) begin
            m_push[d] = 1 << tgt[d];
            if (tgt[d] == m_ptr[d] && m_cnt[d] + 1 < bursts[d]) begin
               m_cnt[d] = m_cnt[d] + 1;
            end else if (tgt[d] != m_ptr[d] && bursts[d] > 1) begin
               m_ptr[d] = tgt[d];
               m_cnt[d] = 1;
            end else begin
               m_ptr[d] = (tgt[d] + 1) % 4;
               m_cnt[d] = 0;
            end
         end else begin
            m_push[d] = 0;
         end
      end
      m_idle = g ? 0 : 1;
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      enable     = 1'b0;
      fifo_empty = 1'b1;
      dest_full  = 4'd0;
      @(posedge clk);
      #1;
      chk("rst_push1", 32'(push1), 0);
      chk("rst_idle1", 32'(idle1), 1);
      chk("rst_pop3", 32'(pop3), 0);
      chk("rst_sel3", 32'(sel3), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      sel_log1.delete();
      sel_log3.delete();
   endtask

   // Streams a given number of source words; the cycle budget bounds the wait on the DUT draining them.
   task automatic stream(input int words, input logic [3:0] full, input int budget);
      int left = words;
      for (int c = 0; c < budget && left > 0; c++) begin
         step(1'b1, 1'b0, full);
         if (last_g) left--;
      end
      chk("stream_drained", left, 0);
      step(1'b1, 1'b1, full);
   endtask

   initial begin
      int exp_rot [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp_skip [4] = '{0, 2, 3, 0};
      int exp_b3 [6] = '{0, 0, 0, 1, 1, 1};
      int exp_b3f [6] = '{0, 0, 1, 1, 1, 2};
      int left;

      model_reset();
      do_reset();

      stream(8, 4'b0000, 20);
      chk("rot_len", sel_log1.size(), 8);
      for (int i = 0; i < 8 && i < sel_log1.size(); i++) chk("rot_sel", sel_log1[i], exp_rot[i]);
      chk("rot_idle", 32'(idle1), 1);

      do_reset();
      stream(4, 4'b0010, 20);
      chk("skip_len", sel_log1.size(), 4);
      for (int i = 0; i < 4 && i < sel_log1.size(); i++) chk("skip_sel", sel_log1[i], exp_skip[i]);

      do_reset();
      stream(6, 4'b0000, 20);
      chk("burst_len", sel_log3.size(), 6);
      for (int i = 0; i < 6 && i < sel_log3.size(); i++) chk("burst_sel", sel_log3[i], exp_b3[i]);

      do_reset();
      left = 6;
      for (int c = 0; c < 20 && left > 0; c++) begin
         step(1'b1, 1'b0, (left <= 4) ? 4'b0001 : 4'b0000);
         if (last_g) left--;
      end
      chk("burstf_len", sel_log3.size(), 6);
      for (int i = 0; i < 6 && i < sel_log3.size(); i++) chk("burstf_sel", sel_log3[i], exp_b3f[i]);

      do_reset();
      step(1'b1, 1'b0, 4'b0000);
      step(1'b1, 1'b0, 4'b0000);
      repeat (3) step(1'b1, 1'b0, 4'b1111);
      enable = 1'b1;
      fifo_empty = 1'b0;
      dest_full = 4'b0111;
      #1;
      chk("stall_release_sel1", 32'(sel1), 3);
      step(1'b1, 1'b0, 4'b0111);
      repeat (3) step(1'b1, 1'b1, 4'b0000);
      repeat (4) step(1'b1, 1'b0, 4'b0000);

      repeat (3) step(1'b1, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000);
      repeat (2) step(1'b0, 1'b0, 4'b0000);

      step(1'b1, 1'b0, 4'b0000);
      enable = 1'b1;
      fifo_empty = 1'b0;
      dest_full = 4'b0000;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_push1", 32'(push1), 0);
      chk("arst_pop1", 32'(pop1), 0);
      chk("arst_sel1", 32'(sel1), 0);
      chk("arst_push3", 32'(push3), 0);
      chk("arst_idle3", 32'(idle3), 1);
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      enable = 1'b1;
      #1;
      chk("post_rst_sel1", 32'(sel1), 0);
      chk("post_rst_sel3", 32'(sel3), 0);

      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
              ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'b0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_demux_ctrl.md
# rr_demux_ctrl

Round-robin scheduler that sequences the 4-way 10-bit `demux4x1` distribution stage of the Project 2 datapath. It pops words from the shared source FIFO, drives the demux `select`, and pushes each word into one of four destination FIFOs. Destinations whose full flag is set are skipped, and each destination may hold the grant for up to `BURST` consecutive words. Push strobes are delayed one cycle so they line up with the registered demux outputs.

## Interface
- `BURST`, default 1: maximum consecutive words granted to one destination before rotating (1..15).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset; asserted at 0, all state cleared immediately.
- `enable` in 1: 1 = scheduling allowed; 0 = finish the in-flight push, then hold.
- `fifo_empty` in 1: source FIFO empty (first-word-fall-through, so data is valid while not empty).
- `dest_full` in 4: per-destination almost-full, bit k for `out_k`. Must assert with at least 1 free slot.
- `pop` in/out: out 1: source FIFO read strobe (combinational).
- `select` out 2: demux select (combinational), index of the granted destination.
- `push` out 4: one-hot destination FIFO write strobes (registered).
- `idle` out 1: registered; 1 when no grant was issued in the previous cycle.

## Operation
- State: `ptr[1:0]` is the current destination, `burst_cnt[3:0]` counts words granted to `ptr`, `push_q[3:0]` is the push register.
- Eligible destination k: `dest_full[k] == 0`.
- Grant condition in a cycle: `enable == 1`, `fifo_empty == 0`, and at least one eligible destination.
- Grant target: the first eligible destination in search order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4, 2-bit wrap).
- When a grant is issued:
  - `pop = 1` and `select = target`.
  - At the edge, `push_q` becomes onehot(target).
- Pointer and counter update on grant:
  - If target == `ptr` and `burst_cnt + 1 < BURST`: `ptr` is held and `burst_cnt` increments.
  - Otherwise (burst complete, or `ptr` was skipped): `ptr` becomes target+1 (mod 4) and `burst_cnt` becomes 0.
  - Exception: if target != `ptr` and `BURST > 1`, then `ptr` becomes target and `burst_cnt` becomes 1. The burst starts at the new holder; if `BURST == 1`, the normal advance applies.
- No grant: `pop = 0`, `select` holds `ptr`, `push_q` becomes 0, and `ptr`/`burst_cnt` are unchanged.
- All destinations full: no grant and no pointer movement. Resumes at the first eligible destination from `ptr`.
- `enable` falling: the grant is suppressed in the same cycle, and an already-registered push still completes next cycle.
- `BURST == 1` gives pure round robin, one word per destination.

## Timing
- Cycle N: grant; `pop`/`select` asserted combinationally. The source FIFO advances and the demux captures the word at the end of N.
- Cycle N+1: `push[target] = 1`, exactly while the demux `out_target` holds the word. Latency from pop to push is 1 cycle.
- Back-to-back grants sustain 1 word per cycle. `push` is one-hot or zero and never has two bits set.
- `dest_full` sampled in N ignores the push landing in N, so the destination FIFO threshold must be depth-1 or lower.
- Reset asserted (`reset == 0`), asynchronously:
  - `ptr` = 0, `burst_cnt` = 0, `push` = 0, `idle` = 1.
  - `pop` = 0 and `select` = 0 (gated while in reset).
  - A word popped in the cycle before reset is dropped; the FIFOs are reset together with this block.
- Release of reset: the first grant can occur in the first cycle after `reset` returns to 1.
- `idle` is the registered negation of the grant condition: 1 in the cycle after any non-grant cycle.

## Test plan
- **Basic rotation:** `BURST=1`, source holds 8 words, `dest_full=0000`, `enable=1` -> `pop` high for 8 cycles; `select` = 0,1,2,3,0,1,2,3; `push` = 0001,0010,0100,1000,... each one cycle after its pop; `idle` = 1 after drain.
- **Skip full:** `BURST=1`, `dest_full=0010` (dest 1 full), 4 words -> destinations 0,2,3,0 in order, and `push[1]` is never asserted.
- **Burst mode:** `BURST=3`, 6 words, none full -> `select` = 0,0,0,1,1,1. With `dest_full[0]` rising after the 2nd word: selects 0,0,1,1,1,2.
- **Stall/empty:** all destinations full with the source non-empty -> `pop=0`, `push=0`, `ptr` held. Release `dest_full[3]` with `ptr=2` -> next grant goes to 3. `fifo_empty=1` mid-stream -> no pop or push until data returns, then rotation resumes at the correct pointer.
- **Enable and reset:**
  - Drop `enable` during streaming -> the last push still appears one cycle later, with no further pops.
  - Assert `reset=0` asynchronously mid-cycle -> `push`, `pop` and `select` go to 0 immediately. After release, the first grant goes to dest 0.
